// File: rtl/core_ifq.sv
// rtl/core_ifq.sv - instruction fetch queue with credit-based prefetch
//
// Purpose: DEPTH-entry FIFO of {pc, instruction} pairs between the fetch PC
// generator / fixed-latency instruction bus and decode. Requests are issued
// only while a queue slot is guaranteed for the response. A jump flushes the
// queue and redirects fetch within a single cycle.
//
// Ports:
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   jump_flag_i       redirect request (branch, jump, interrupt)
//   jump_addr_i       redirect target
//   ibus_req_o        fetch request valid this cycle
//   ibus_addr_o       fetch address (aligned to instruction size)
//   ibus_data_i       fetch data, valid exactly 1 cycle after a request
//   deq_vld_o         head entry valid
//   deq_ready_i       decode accepts head
//   deq_inst_o        head instruction
//   deq_pc_o          head PC
//   level_o           occupied entries
module core_ifq #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    jump_flag_i,
  input  logic [ADDR_WIDTH-1:0]   jump_addr_i,
  output logic                    ibus_req_o,
  output logic [ADDR_WIDTH-1:0]   ibus_addr_o,
  input  logic [DATA_WIDTH-1:0]   ibus_data_i,
  output logic                    deq_vld_o,
  input  logic                    deq_ready_i,
  output logic [DATA_WIDTH-1:0]   deq_inst_o,
  output logic [ADDR_WIDTH-1:0]   deq_pc_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int STEP = DATA_WIDTH / 8;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STEP - 1));
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(STEP);

  logic [ADDR_WIDTH-1:0] fpc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic                  run;
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         wptr;
  logic [CW-1:0]         count;
  logic                  credit_ok;
  logic                  pop;
  logic                  push;

  // A request needs a free slot counting the response still on the bus;
  // a pop this cycle frees one, which keeps full-rate streaming at DEPTH=2.
  assign credit_ok   = ({1'b0, count} + (CW + 1)'(inflight)) < (CW + 1)'(DEPTH);
  assign deq_vld_o   = (count != '0) & ~jump_flag_i;
  assign pop         = deq_vld_o & deq_ready_i;
  assign ibus_req_o  = run & ~jump_flag_i & (credit_ok | pop);
  assign ibus_addr_o = fpc & ALIGN_MASK;
  // A response landing in a flush cycle belongs to the old stream.
  assign push        = inflight & ~jump_flag_i;

  assign deq_inst_o  = inst_mem[rptr];
  assign deq_pc_o    = pc_mem[rptr];
  assign level_o     = count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fpc         <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      run         <= 1'b0;
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      run <= 1'b1;
      if (jump_flag_i) begin
        fpc      <= jump_addr_i & ALIGN_MASK;
        inflight <= 1'b0;
        rptr     <= '0;
        wptr     <= '0;
        count    <= '0;
      end else begin
        inflight <= ibus_req_o;
        if (ibus_req_o) begin
          fpc         <= ibus_addr_o + PC_STEP;
          inflight_pc <= ibus_addr_o;
        end
        if (push) begin
          inst_mem[wptr] <= ibus_data_i;
          pc_mem[wptr]   <= inflight_pc;
          wptr           <= wptr + PW'(1);
        end
        if (pop) begin
          rptr <= rptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_ifq.sv
// tb/tb_core_ifq.sv - self-checking bench for core_ifq
module tb_core_ifq;

  logic        clk_i;
  logic        rst_n_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic [31:0] ibus_data_i;
  logic        deq_vld_o;
  logic        deq_ready_i;
  logic [31:0] deq_inst_o;
  logic [31:0] deq_pc_o;
  logic [2:0]  level_o;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        w_vld;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic [2:0]  w_level;

  core_ifq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_data_i(ibus_data_i),
    .deq_vld_o(deq_vld_o), .deq_ready_i(deq_ready_i),
    .deq_inst_o(deq_inst_o), .deq_pc_o(deq_pc_o), .level_o(level_o)
  );

  core_ifq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .jump_flag_i(1'b0), .jump_addr_i(32'h0),
    .ibus_req_o(w_req), .ibus_addr_o(w_addr), .ibus_data_i(w_data),
    .deq_vld_o(w_vld), .deq_ready_i(1'b1),
    .deq_inst_o(w_inst), .deq_pc_o(w_pc), .level_o(w_level)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: fetch stream expectations and queue occupancy.
  int          m_lvl;
  logic [31:0] m_exp_pc;
  logic [31:0] m_req_addr;
  logic        prev_req;
  logic [31:0] prev_addr;
  logic        w_prev_req;
  logic [31:0] w_prev_addr;
  logic [31:0] w_pcs[$];

  // Values sampled in the most recent cycle.
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_vld;
  logic [31:0] s_pc;
  logic [2:0]  s_level;

  logic [31:0] hold_pc;
  logic        saw_200;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl       = 0;
    m_exp_pc    = 32'h0;
    m_req_addr  = 32'h0;
    prev_req    = 1'b0;
    prev_addr   = 32'h0;
    w_prev_req  = 1'b0;
    w_prev_addr = 32'h0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req",   64'(ibus_req_o),  64'(0));
    chk("rst_addr",  64'(ibus_addr_o), 64'(0));
    chk("rst_vld",   64'(deq_vld_o),   64'(0));
    chk("rst_inst",  64'(deq_inst_o),  64'(0));
    chk("rst_pc",    64'(deq_pc_o),    64'(0));
    chk("rst_level", 64'(level_o),     64'(0));
    chk("rst_waddr", 64'(w_addr),      64'(32'hFFFF_FFF8));
  endtask

  // One clock cycle: drive inputs at negedge, check settled outputs, then
  // advance the model to what the coming posedge should commit.
  task automatic cycle(input logic ready, input logic jump, input logic [31:0] jaddr);
    logic push;
    logic pop;
    @(negedge clk_i);
    deq_ready_i = ready;
    jump_flag_i = jump;
    jump_addr_i = jaddr;
    ibus_data_i = prev_req ? mem_word(prev_addr) : $urandom;
    w_data      = w_prev_req ? mem_word(w_prev_addr) : $urandom;
    #1;
    s_req   = ibus_req_o;
    s_addr  = ibus_addr_o;
    s_vld   = deq_vld_o;
    s_pc    = deq_pc_o;
    s_level = level_o;

    chk("level", 64'(level_o), 64'(m_lvl));
    chk("vld", 64'(deq_vld_o), 64'((m_lvl != 0) && !jump));
    if (jump) chk("req_in_jump", 64'(ibus_req_o), 64'(0));
    if (ibus_req_o) chk("req_addr", 64'(ibus_addr_o), 64'(m_req_addr));
    pop = deq_vld_o && ready;
    if (pop) begin
      chk("deq_pc",   64'(deq_pc_o),   64'(m_exp_pc));
      chk("deq_inst", 64'(deq_inst_o), 64'(mem_word(m_exp_pc)));
    end

    push = prev_req && !jump;
    if (jump) begin
      m_lvl      = 0;
      m_exp_pc   = jaddr & 32'hFFFF_FFFC;
      m_req_addr = jaddr & 32'hFFFF_FFFC;
    end else begin
      m_lvl = m_lvl + int'(push) - int'(pop);
      if (pop) m_exp_pc = m_exp_pc + 32'd4;
      if (ibus_req_o) m_req_addr = m_req_addr + 32'd4;
    end
    prev_req  = ibus_req_o;
    prev_addr = ibus_addr_o;

    if (w_vld && w_pcs.size() < 3) w_pcs.push_back(w_pc);
    w_prev_req  = w_req;
    w_prev_addr = w_addr;
  endtask

  initial begin
    rst_n_i     = 1'b0;
    jump_flag_i = 1'b0;
    jump_addr_i = 32'h0;
    deq_ready_i = 1'b1;
    ibus_data_i = 32'h0;
    w_data      = 32'h0;
    saw_200     = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    chk_reset_vals();

    // Release; first request in E0->E1, first valid from E2, then no bubbles
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cycle(1'b1, 1'b0, 32'h0);
    chk("first_req", 64'(s_req), 64'(1));
    chk("first_addr", 64'(s_addr), 64'(0));
    chk("lat_vld_e1", 64'(s_vld), 64'(0));
    cycle(1'b1, 1'b0, 32'h0);
    chk("lat_vld_e1b", 64'(s_vld), 64'(0));
    cycle(1'b1, 1'b0, 32'h0);
    chk("lat_vld_e2", 64'(s_vld), 64'(1));
    chk("lat_pc_e2", 64'(s_pc), 64'(0));
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("stream_vld", 64'(s_vld), 64'(1));
      chk("stream_req", 64'(s_req), 64'(1));
    end

    // Hold: decode stalls, queue fills to DEPTH and fetch stops
    cycle(1'b0, 1'b0, 32'h0);
    hold_pc = s_pc;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      chk("hold_pc", 64'(s_pc), 64'(hold_pc));
    end
    chk("hold_level", 64'(s_level), 64'(4));
    chk("hold_req", 64'(s_req), 64'(0));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("drain_vld", 64'(s_vld), 64'(1));
    end

    // Redirect with 3 entries queued and one in flight
    cycle(1'b0, 1'b1, 32'h40);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h103);
    chk("jmp_level_before", 64'(s_level), 64'(3));
    chk("jmp_vld", 64'(s_vld), 64'(0));
    cycle(1'b1, 1'b0, 32'h0);
    chk("jmp_req", 64'(s_req), 64'(1));
    chk("jmp_addr", 64'(s_addr), 64'(32'h100));
    cycle(1'b1, 1'b0, 32'h0);
    chk("jmp_vld_j2", 64'(s_vld), 64'(0));
    cycle(1'b1, 1'b0, 32'h0);
    chk("jmp_vld_j3", 64'(s_vld), 64'(1));
    chk("jmp_pc_j3", 64'(s_pc), 64'(32'h100));

    // Back-to-back jumps: only the last target is fetched
    cycle(1'b1, 1'b1, 32'h200);
    cycle(1'b1, 1'b1, 32'h300);
    cycle(1'b1, 1'b0, 32'h0);
    chk("b2b_req", 64'(s_req), 64'(1));
    chk("b2b_addr", 64'(s_addr), 64'(32'h300));
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (s_req && s_addr[31:8] == 24'h2) saw_200 = 1'b1;
    end
    chk("b2b_no_200", 64'(saw_200), 64'(0));

    // Wrap-around fetch from RESET_PC near the top of the address space
    chk("wrap_cnt", 64'(w_pcs.size() >= 3), 64'(1));
    if (w_pcs.size() >= 3) begin
      chk("wrap_pc0", 64'(w_pcs[0]), 64'(32'hFFFF_FFF8));
      chk("wrap_pc1", 64'(w_pcs[1]), 64'(32'hFFFF_FFFC));
      chk("wrap_pc2", 64'(w_pcs[2]), 64'(32'h0000_0000));
    end

    // Randomised traffic with stalls and redirects
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0)
        cycle($urandom_range(0, 3) != 0, 1'b1, $urandom_range(0, 4095));
      else
        cycle($urandom_range(0, 3) != 0, 1'b0, 32'h0);
    end

    // Reset mid-stream with a request in flight
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("pre_rst_req", 64'(s_req), 64'(1));
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk_i);
    model_reset();
    rst_n_i = 1'b1;
    cycle(1'b1, 1'b0, 32'h0);
    chk("restart_req", 64'(s_req), 64'(1));
    chk("restart_addr", 64'(s_addr), 64'(0));
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 24) == 0)
        cycle($urandom_range(0, 2) != 0, 1'b1, $urandom);
      else
        cycle($urandom_range(0, 2) != 0, 1'b0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_ifq.md
# core_ifq

Parametrised instruction fetch queue that sits between the PC generator/instruction bus and the decode stage. It replaces single-entry hold latching with a DEPTH-entry FIFO of {pc, instruction} pairs, and uses credit-based prefetch over a fixed-latency instruction bus. It supports a valid/ready handshake to decode and single-cycle flush-and-redirect on jump or interrupt.

## Interface
- ADDR_WIDTH, 32, instruction address width
- DATA_WIDTH, 32, instruction width; PC step is DATA_WIDTH/8
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- jump_flag_i  in  1  redirect request (branch, jump, interrupt)
- jump_addr_i  in  ADDR_WIDTH  redirect target
- ibus_req_o  out  1  fetch request valid this cycle
- ibus_addr_o  out  ADDR_WIDTH  fetch address
- ibus_data_i  in  DATA_WIDTH  fetch data, valid exactly 1 cycle after an accepted request
- deq_vld_o  out  1  head entry valid
- deq_ready_i  in  1  decode accepts head; low = hold
- deq_inst_o  out  DATA_WIDTH  head instruction
- deq_pc_o  out  ADDR_WIDTH  head PC
- level_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: fetch PC register `fpc`, `inflight` bit, circular buffer with read/write pointers, count, and `run` bit.
- `ibus_addr_o` = `fpc` (low log2(DATA_WIDTH/8) bits forced 0).
- `ibus_req_o` = run & ~jump_flag_i & ((count + inflight < DEPTH) | pop).
  - pop = deq_vld_o & deq_ready_i.
- On each issued request:
  - `fpc` += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
  - `inflight` ← 1 with its PC captured; otherwise `inflight` ← 0.
- The cycle after a request, ibus_data_i and its captured PC are written at the write pointer, unless a flush occurred in between.
- Dequeue:
  - deq_vld_o = (count ≠ 0) & ~jump_flag_i.
  - Head outputs come from the read pointer.
  - On pop the read pointer advances.
  - No empty-queue bypass.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap at DEPTH. Count never exceeds DEPTH; the credit rule guarantees this.
- Flush on jump_flag_i = 1:
  - Count, pointers, `inflight` cleared.
  - Any response arriving next cycle is discarded.
  - `fpc` ← jump_addr_i with low alignment bits zeroed.
  - A simultaneous pop is ignored (deq_vld_o is already 0).
- Back-to-back jumps: the last one wins; no requests are issued while jump_flag_i is high.
- `run` is 0 in reset and becomes 1 on the first clock edge after rst_n_i rises.

## Timing
- Reset values: `fpc` = RESET_PC, ibus_req_o = 0, ibus_addr_o = RESET_PC, deq_vld_o = 0, deq_inst_o = 0, deq_pc_o = 0 (storage cleared), level_o = 0.
- Reset mid-operation: all state returns to reset values immediately; in-flight data is dropped.
- Release followed by edge E0:
  - First request in cycle E0→E1.
  - Data written at E2.
  - deq_vld_o high from E2, i.e. fetch-to-decode latency of 2 cycles.
- Throughput is 1 instruction/cycle sustained with deq_ready_i held high, for every DEPTH ≥ 2.
- Redirect: jump_flag_i high in cycle J → request at jump_addr_i in cycle J+1 → deq_vld_o for the target in cycle J+3.
- Hold: with deq_ready_i low, head outputs are stable. Fetch continues until count + inflight = DEPTH, then ibus_req_o = 0.
- Combinational paths: deq_ready_i → ibus_req_o and jump_flag_i → ibus_req_o/deq_vld_o. No path from ibus_data_i to any output.

## Test plan
- Reset, DEPTH=4, deq_ready_i=1, memory returns word = address → deq_pc_o 0,4,8,… with deq_inst_o equal to deq_pc_o; first valid 2 cycles after release; then one per cycle with no bubbles.
- deq_ready_i=0 for 10 cycles after fill → level_o stays 4, ibus_req_o=0, head pc=0 stable; release → 0,4,8,12,16 delivered contiguously.
- Pulse jump_flag_i with jump_addr_i=0x103 while 3 entries are queued and one is in flight → deq_vld_o=0 in that cycle, next request address 0x100, stale in-flight word never dequeued, target valid at J+3.
- Jumps in consecutive cycles to 0x200 then 0x300 → only 0x300 is fetched; 0x200 is never requested.
- RESET_PC=32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap-around).
- Assert rst_n_i low mid-stream with a request in flight → all outputs take reset values immediately; after release, fetch restarts at RESET_PC.
